exec_unit: RTL and testbench
============================

Name: exec_unit

Overview:
- Execute stage that sits directly downstream of the register file's read ports and upstream of its write port.
- Consumes two register operands plus an immediate and computes single-cycle ALU results or a multi-cycle signed multiply.
- Drives the register-file write port (w, waddr, wdata) and a zero flag used by branch logic.
- Accepts one instruction per cycle through a valid/ready handshake; stalls issue while a multiply is iterating.

Parameters:
- DATA_WIDTH, 8, operand/result width in bits.
- ADDR_WIDTH, 3, register address width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  instruction present on op/dest/a/b/imm.
- in_ready  output  1  unit can accept an instruction this cycle.
- op  input  3  operation code (see Behaviour).
- dest  input  ADDR_WIDTH  destination register.
- a  input  DATA_WIDTH  operand A (register read port 1).
- b  input  DATA_WIDTH  operand B (register read port 2).
- imm  input  DATA_WIDTH  immediate operand.
- wb_w  output  1  register write enable, one-cycle pulse.
- wb_waddr  output  ADDR_WIDTH  register write address.
- wb_wdata  output  DATA_WIDTH  register write data.
- zero_flag  output  1  set when the last completed non-NOP result was 0.
- busy  output  1  multiply in progress.

Behaviour:
- Accept occurs on a rising edge when in_valid && in_ready. Inputs are sampled only at accept.
- in_ready = (state == IDLE). busy = (state == MUL).
- Opcodes; all arithmetic is modulo 2^DATA_WIDTH unless stated:
  - 000 ADD: a+b.
  - 001 SUB: a−b.
  - 010 ADDI: a+imm.
  - 011 MUL: signed a × signed b.
  - 100 MULI: signed a × signed imm.
  - 101 MOV: b.
  - 110 NOP.
  - 111 reserved, treated as NOP.
- MUL/MULI result is bits [2·DATA_WIDTH−1 : DATA_WIDTH] of the full two's-complement signed product (high half).
- States: IDLE, MUL.
- IDLE:
  - Accepting a single-cycle op (ADD/SUB/ADDI/MOV) registers its result. On the next cycle wb_wdata = result, wb_waddr = dest, wb_w = 1 for exactly one cycle, and zero_flag = (result == 0).
  - State stays IDLE, so back-to-back single-cycle ops run at one per cycle.
- Accepting MUL/MULI:
  - Latches the operands and dest, clears the accumulator, loads iteration counter = DATA_WIDTH, and enters MUL.
  - wb_w is 0 on the following cycle.
- MUL:
  - One shift-add iteration per cycle for DATA_WIDTH cycles. The internal algorithm is free; cycle timing is not.
  - On the final iteration edge: state → IDLE, and the outputs take effect in the next cycle (wb_w = 1, wb_waddr = latched dest, wb_wdata = high half, zero_flag updated).
  - Accept at edge T gives wb_w high in cycle T+DATA_WIDTH+1. in_ready is low for exactly DATA_WIDTH cycles.
- Outputs not being written hold their previous values. wb_w is 0 in every cycle without a completion.
- dest == 0: the result is computed and zero_flag updates, but wb_w stays 0 (register 0 is not written).
- NOP/reserved: accepted in one cycle; no wb_w pulse; zero_flag unchanged.
- in_valid while in_ready = 0: ignored, no state change. The upstream holds the instruction until accepted.
- Reset (any time, including mid-multiply):
  - State → IDLE; counter and accumulator cleared.
  - Outputs: wb_w = 0, wb_waddr = 0, wb_wdata = 0, zero_flag = 0, busy = 0, in_ready = 1.
  - An in-flight multiply is discarded and produces no write-back after reset releases.

Test Plan:
- ADD a=0x7F, b=0x01, dest=3 -> next cycle wb_w=1, wb_waddr=3, wb_wdata=0x80, zero_flag=0; wb_w=0 the cycle after.
- SUB a=0x05, b=0x05, dest=2, then ADDI a=0x10, imm=0xF0, dest=4 back-to-back -> wb pulses on consecutive cycles: 0x00/zero_flag=1, then 0x00/zero_flag=1. in_ready stays 1 throughout.
- MUL a=0x40, b=0x40, dest=5 accepted at edge T -> in_ready=0 and busy=1 for 8 cycles; wb_w=1 only in cycle T+9 with wb_wdata=0x10. A second in_valid held during busy is accepted only once in_ready=1.
- MULI a=0xC0 (−64), imm=0x40 -> wb_wdata=0xF0. MUL a=0x80, b=0x80 -> wb_wdata=0x40. MUL a=0x00, b=0x37 -> wb_wdata=0x00, zero_flag=1.
- MOV b=0x5A, dest=0 -> wb_w stays 0 and zero_flag=0. NOP/op=111 -> no wb_w pulse and zero_flag unchanged.
- Assert reset 3 cycles into a MUL -> all outputs take their reset values immediately (asynchronous). After release: no wb_w pulse, in_ready=1, and a new ADD completes normally.

Source files
------------

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus an iterative signed multiply.
// Results go out on the register-file write port one cycle after they finish.
module exec_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] dest,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic                  wb_w,
  output logic [ADDR_WIDTH-1:0] wb_waddr,
  output logic [DATA_WIDTH-1:0] wb_wdata,
  output logic                  zero_flag,
  output logic                  busy
);

  localparam int CntW = $clog2(DATA_WIDTH + 1);
  localparam int ProdW = 2 * DATA_WIDTH;

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpAddi = 3'b010;
  localparam logic [2:0] OpMul  = 3'b011;
  localparam logic [2:0] OpMuli = 3'b100;
  localparam logic [2:0] OpMov  = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t state, stateNext;

  logic [ProdW-1:0]      mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [ProdW-1:0]      acc;
  logic [ProdW-1:0]      accNext;
  logic [ProdW-1:0]      term;
  logic [CntW-1:0]       counter;
  logic [ADDR_WIDTH-1:0] destLatched;
  logic [DATA_WIDTH-1:0] aluResult;
  logic                  aluWrites;
  logic                  isMulOp;
  logic                  accept;
  logic                  lastIter;

  assign in_ready = (state == IDLE);
  assign busy     = (state == MUL);
  assign accept   = in_valid && in_ready;
  assign isMulOp  = (op == OpMul) || (op == OpMuli);
  assign lastIter = (counter == CntW'(1));

  // Single-cycle ALU result and whether the opcode produces a result at all
  always_comb begin
    aluResult = '0;
    aluWrites = 1'b0;
    case (op)
      OpAdd:   begin aluResult = a + b;   aluWrites = 1'b1; end
      OpSub:   begin aluResult = a - b;   aluWrites = 1'b1; end
      OpAddi:  begin aluResult = a + imm; aluWrites = 1'b1; end
      OpMov:   begin aluResult = b;       aluWrites = 1'b1; end
      default: begin aluResult = '0;      aluWrites = 1'b0; end
    endcase
  end

  // Shift-add step; the multiplier's top bit carries negative weight, so the
  // last iteration subtracts instead of adding
  always_comb begin
    term    = mplier[0] ? mcand : '0;
    accNext = lastIter ? (acc - term) : (acc + term);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state: enter MUL on a multiply accept, leave after the final iteration
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept && isMulOp) stateNext = MUL;
      MUL:     if (lastIter) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: operand latching, multiply iterations and write-back outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      counter     <= '0;
      destLatched <= '0;
      wb_w        <= 1'b0;
      wb_waddr    <= '0;
      wb_wdata    <= '0;
      zero_flag   <= 1'b0;
    end else begin
      wb_w <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (isMulOp) begin
              mcand       <= {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
              mplier      <= (op == OpMul) ? b : imm;
              acc         <= '0;
              counter     <= CntW'(DATA_WIDTH);
              destLatched <= dest;
            end else if (aluWrites) begin
              zero_flag <= (aluResult == '0);
              if (dest != '0) begin
                wb_w     <= 1'b1;
                wb_waddr <= dest;
                wb_wdata <= aluResult;
              end
            end
          end
        end
        MUL: begin
          acc     <= accNext;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          counter <= counter - CntW'(1);
          if (lastIter) begin
            zero_flag <= (accNext[ProdW-1:DATA_WIDTH] == '0);
            if (destLatched != '0) begin
              wb_w     <= 1'b1;
              wb_waddr <= destLatched;
              wb_wdata <= accNext[ProdW-1:DATA_WIDTH];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: the driver pushes expected write-back events,
// a negedge monitor pops and compares them against the DUT's outputs.
module tb_exec_unit;

  localparam int W = 8;
  localparam int AW = 3;

  logic          clk;
  logic          reset;
  logic          inValid;
  logic          in_ready;
  logic [2:0]    opIn;
  logic [AW-1:0] destIn;
  logic [W-1:0]  aIn, bIn, immIn;
  logic          wbW;
  logic [AW-1:0] wbWaddr;
  logic [W-1:0]  wbWdata;
  logic          zeroFlag;
  logic          busy;

  typedef struct {
    int           cycle;
    bit           write;
    logic [AW-1:0] addr;
    logic [W-1:0] data;
    bit           zero;
  } expEntry_t;

  expEntry_t expQ[$];
  expEntry_t e;

  int  total = 0;
  int  bad = 0;
  int  cycleCount = 0;
  int  busyStart = -10;
  int  busyEnd = -20;
  bit  zeroModel = 1'b0;
  bit  expReady;

  exec_unit #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(inValid),
    .in_ready(in_ready),
    .op(opIn),
    .dest(destIn),
    .a(aIn),
    .b(bIn),
    .imm(immIn),
    .wb_w(wbW),
    .wb_waddr(wbWaddr),
    .wb_wdata(wbWdata),
    .zero_flag(zeroFlag),
    .busy(busy)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: cycle N is the interval following the N-th rising edge
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  // Behavioural reference: plain arithmetic on the opcode definitions
  function automatic logic [W-1:0] refResult(input logic [2:0] o, input logic [W-1:0] ra,
                                             input logic [W-1:0] rb, input logic [W-1:0] ri);
    int sa, sx;
    logic [31:0] p;
    sa = int'($signed(ra));
    case (o)
      3'b000:  return ra + rb;
      3'b001:  return ra - rb;
      3'b010:  return ra + ri;
      3'b011: begin sx = int'($signed(rb)); p = sa * sx; return p[15:8]; end
      3'b100: begin sx = int'($signed(ri)); p = sa * sx; return p[15:8]; end
      3'b101:  return rb;
      default: return '0;
    endcase
  endfunction

  // Issue one instruction, wait for acceptance, and record the expected response
  task automatic applyStimulus(input logic [2:0] o, input logic [AW-1:0] d,
                               input logic [W-1:0] ra, input logic [W-1:0] rb, input logic [W-1:0] ri);
    int waitCount = 0;
    int acceptCycle;
    bit isMul, hasResult;
    logic [W-1:0] r;
    expEntry_t n;
    opIn = o; destIn = d; aIn = ra; bIn = rb; immIn = ri;
    inValid = 1'b1;
    while (!in_ready && waitCount < 100) begin
      @(negedge clk);
      waitCount++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
      inValid = 1'b0;
      return;
    end
    acceptCycle = cycleCount + 1;
    isMul = (o == 3'b011) || (o == 3'b100);
    hasResult = (o <= 3'b101);
    r = refResult(o, ra, rb, ri);
    if (hasResult) zeroModel = (r == '0);
    n.cycle = isMul ? acceptCycle + W : acceptCycle;
    n.write = hasResult && (d != '0);
    n.addr  = d;
    n.data  = r;
    n.zero  = zeroModel;
    expQ.push_back(n);
    if (isMul) begin
      busyStart = acceptCycle;
      busyEnd   = acceptCycle + W - 1;
    end
    @(negedge clk);
    inValid = 1'b0;
  endtask

  // Monitor: handshake status every cycle, write-back events against the queue
  always @(negedge clk) begin
    if (!reset) begin
      expReady = !(cycleCount >= busyStart && cycleCount <= busyEnd);
      checkOutput("in_ready", 32'(in_ready), 32'(expReady));
      checkOutput("busy", 32'(busy), 32'(!expReady));
      if (wbW) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_wb_w", 32'(wbW), 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("wb_cycle", 32'(cycleCount), 32'(e.cycle));
          checkOutput("wb_expected_write", 32'(1), 32'(e.write));
          checkOutput("wb_waddr", 32'(wbWaddr), 32'(e.addr));
          checkOutput("wb_wdata", 32'(wbWdata), 32'(e.data));
          checkOutput("zero_flag", 32'(zeroFlag), 32'(e.zero));
        end
      end else if (expQ.size() > 0 && expQ[0].cycle <= cycleCount) begin
        e = expQ.pop_front();
        checkOutput("wb_w_pulse", 32'(0), 32'(e.write));
        checkOutput("silent_cycle", 32'(cycleCount), 32'(e.cycle));
        checkOutput("zero_flag_hold", 32'(zeroFlag), 32'(e.zero));
      end
    end
  end

  task automatic checkResetValues();
    checkOutput("rst_wb_w", 32'(wbW), 32'd0);
    checkOutput("rst_wb_waddr", 32'(wbWaddr), 32'd0);
    checkOutput("rst_wb_wdata", 32'(wbWdata), 32'd0);
    checkOutput("rst_zero_flag", 32'(zeroFlag), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Main sequence: directed cases, mid-multiply reset, then randomized traffic
  initial begin
    int drain;
    reset = 1'b1; inValid = 1'b0;
    opIn = '0; destIn = '0; aIn = '0; bIn = '0; immIn = '0;
    repeat (3) @(negedge clk);
    checkResetValues();
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(3'b000, 3'd3, 8'h7F, 8'h01, 8'h00);
    @(negedge clk);
    applyStimulus(3'b001, 3'd2, 8'h05, 8'h05, 8'h00);
    applyStimulus(3'b010, 3'd4, 8'h10, 8'h00, 8'hF0);
    applyStimulus(3'b011, 3'd5, 8'h40, 8'h40, 8'h00);
    applyStimulus(3'b000, 3'd6, 8'h11, 8'h22, 8'h00);
    applyStimulus(3'b100, 3'd1, 8'hC0, 8'h00, 8'h40);
    applyStimulus(3'b011, 3'd7, 8'h80, 8'h80, 8'h00);
    applyStimulus(3'b011, 3'd2, 8'h00, 8'h37, 8'h00);
    applyStimulus(3'b000, 3'd1, 8'h01, 8'h01, 8'h00);
    applyStimulus(3'b101, 3'd0, 8'h00, 8'h5A, 8'h00);
    applyStimulus(3'b001, 3'd3, 8'h09, 8'h09, 8'h00);
    applyStimulus(3'b110, 3'd4, 8'h00, 8'h00, 8'h00);
    applyStimulus(3'b111, 3'd5, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);

    applyStimulus(3'b011, 3'd6, 8'h12, 8'h34, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checkResetValues();
    expQ.delete();
    zeroModel = 1'b0;
    busyStart = -10;
    busyEnd = -20;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (W + 3) @(negedge clk);
    applyStimulus(3'b000, 3'd2, 8'h21, 8'h03, 8'h00);

    for (int i = 0; i < 60; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                    8'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    drain = 0;
    while (expQ.size() > 0 && drain < 50) begin
      @(negedge clk);
      drain++;
    end
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
